// File: rtl/neuron_mac_scheduler.sv
// Neuron MAC scheduler: steps one shared multiplier across N_INPUTS synapses,
// accumulating products with per-step signed saturation.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid may not depend on ready, and the producer holds its data until the transfer.
module neuron_mac_scheduler #(
    parameter int N_INPUTS = 4,
    parameter int WIDTH    = 32,
    localparam int IW      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic                      w_we,
    input  logic [IW-1:0]             w_addr,
    input  logic [WIDTH-1:0]          w_data,
    output logic [WIDTH-1:0]          mul_in,
    output logic [WIDTH-1:0]          mul_const,
    input  logic [WIDTH-1:0]          mul_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_sum,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_sat;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] in_reg [N_INPUTS];
    logic [WIDTH-1:0] weight [N_INPUTS];
    logic             accept;
    logic             last_step;
    logic             w_addr_ok;

    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (idx == IW'(N_INPUTS - 1));
    assign w_addr_ok = (32'(w_addr) < N_INPUTS);

    // Sign-extend both operands by one bit; a mismatch of the top two bits means overflow.
    assign sum_ext = {acc[WIDTH-1], acc} + {mul_out[WIDTH-1], mul_out};

    always_comb begin
        acc_sat = sum_ext[WIDTH-1:0];
        if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
            if (sum_ext[WIDTH])
                acc_sat = {1'b1, {(WIDTH-1){1'b0}}};
            else
                acc_sat = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = MUL;
            MUL:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
        out_sum   = (state == DONE) ? acc : '0;
        mul_in    = '0;
        mul_const = '0;
        if (state == MUL) begin
            mul_in    = in_reg[idx];
            mul_const = weight[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            acc   <= '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                in_reg[i] <= '0;
                weight[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                idx <= '0;
                acc <= '0;
                for (int i = 0; i < N_INPUTS; i++)
                    in_reg[i] <= in_data[i*WIDTH +: WIDTH];
            end
            if (state == MUL) begin
                acc <= acc_sat;
                idx <= last_step ? '0 : idx + 1'b1;
            end
            // Weights only change in IDLE so a vector always sees one consistent set.
            if (w_we && (state == IDLE) && w_addr_ok)
                weight[w_addr] <= w_data;
        end
    end

endmodule

// File: tb/tb_neuron_mac_scheduler.sv
// Directed bench for neuron_mac_scheduler with an adder stub standing in for
// the shared multiplier (mul_out = mul_in + mul_const, wrapping).
module tb_neuron_mac_scheduler;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           w_we;
    logic [1:0]     w_addr;
    logic [W-1:0]   w_data;
    logic [W-1:0]   mul_in;
    logic [W-1:0]   mul_const;
    logic [W-1:0]   mul_out;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_sum;
    logic           busy;

    int n_checks;
    int n_fail;

    neuron_mac_scheduler #(.N_INPUTS(N), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .mul_in    (mul_in),
        .mul_const (mul_const),
        .mul_out   (mul_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    assign mul_out = mul_in + mul_const;

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] w;
        logic [N*W-1:0] d;
        logic [W-1:0]   exp;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [N*W-1:0] pack4(logic [W-1:0] a, logic [W-1:0] b,
                                             logic [W-1:0] c, logic [W-1:0] d);
        return {d, c, b, a};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_weights(input logic [N*W-1:0] w);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            w_we   = 1'b1;
            w_addr = 2'(i);
            w_data = w[i*W +: W];
        end
        @(negedge clk);
        w_we = 1'b0;
    endtask

    // Drives one accepted vector; returns at the negedge of the first MUL cycle.
    task automatic send(input logic [N*W-1:0] d, input logic we, input logic [1:0] addr,
                        input logic [W-1:0] wd);
        @(negedge clk);
        check("accept_in_ready", W'(in_ready), W'(1));
        in_valid = 1'b1;
        in_data  = d;
        w_we     = we;
        w_addr   = addr;
        w_data   = wd;
        @(negedge clk);
        in_valid = 1'b0;
        w_we     = 1'b0;
    endtask

    // Sends a vector, checks every multiplier operand pair, and returns in the
    // first DONE cycle (5 cycles after the accept).
    task automatic run_mul(input logic [N*W-1:0] w, input logic [N*W-1:0] d,
                           input logic we, input logic [1:0] addr, input logic [W-1:0] wd,
                           input string tag);
        send(d, we, addr, wd);
        for (int k = 0; k < N; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("%s_mul_in%0d", tag, k), mul_in, d[k*W +: W]);
            check($sformatf("%s_mul_const%0d", tag, k), mul_const, w[k*W +: W]);
            check($sformatf("%s_early_valid%0d", tag, k), W'(out_valid), W'(0));
        end
        @(negedge clk);
        check({tag, "_valid_lat5"}, W'(out_valid), W'(1));
        check({tag, "_mul_in_idle"}, mul_in, '0);
        check({tag, "_mul_const_idle"}, mul_const, '0);
        check({tag, "_in_ready_busy"}, W'(in_ready), W'(0));
    endtask

    task automatic finish_out(input logic [W-1:0] exp, input string tag);
        check({tag, "_sum"}, out_sum, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, W'(in_ready), W'(1));
        check({tag, "_busy_after"}, W'(busy), W'(0));
        check({tag, "_valid_after"}, W'(out_valid), W'(0));
    endtask

    logic [N*W-1:0] d5;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        out_ready = 1'b0;
        d5        = pack4(32'd5, 32'd5, 32'd5, 32'd5);

        vecs[0] = '{pack4(32'd1, 32'd2, 32'd3, 32'd4), pack4(32'd10, 32'd20, 32'd30, 32'd40), 32'd110};
        vecs[1] = '{pack4(32'h7FFFFFF0, 32'h7FFFFFF0, 32'h7FFFFFF0, 32'h7FFFFFF0),
                    pack4(32'h10, 32'h10, 32'h10, 32'h10), 32'h80000000};
        // The adder stub wraps step 2 to 0x80000000, so the running sum drops to -1.
        vecs[2] = '{pack4(32'h7FFFFFFF, 32'd1, 32'd0, 32'd0), pack4(32'd0, 32'h7FFFFFFF, 32'd0, 32'd0),
                    32'hFFFFFFFF};
        vecs[3] = '{pack4(32'h7FFFFFFF, 32'd1, 32'd0, 32'd0), pack4(32'd0, 32'h7FFFFFFE, 32'd0, 32'd0),
                    32'h7FFFFFFF};
        // Clamp at step 2 then subtract: differs from a clamp applied only at the end.
        vecs[4] = '{pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'hC0000000, 32'd0), '0, 32'h3FFFFFFF};
        vecs[5] = '{pack4(32'hFFFFFFFE, 32'd3, 32'hFFFFFFFC, 32'd5), pack4(32'd1, 32'd1, 32'd1, 32'd1),
                    32'd6};
        vecs[6] = '{pack4(32'h80000000, 32'h80000000, 32'h40000000, 32'd0), '0, 32'hC0000000};

        repeat (3) @(negedge clk);
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_sum", out_sum, '0);
        check("rst_mul_in", mul_in, '0);
        check("rst_mul_const", mul_const, '0);
        check("rst_busy", W'(busy), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            write_weights(vecs[i].w);
            run_mul(vecs[i].w, vecs[i].d, 1'b0, 2'd0, '0, $sformatf("vec%0d", i));
            finish_out(vecs[i].exp, $sformatf("vec%0d", i));
        end

        // DONE held with out_ready low; a competing in_valid must not be latched.
        write_weights(vecs[0].w);
        run_mul(vecs[0].w, vecs[0].d, 1'b0, 2'd0, '0, "hold");
        in_valid = 1'b1;
        in_data  = d5;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("hold_sum%0d", k), out_sum, 32'd110);
            check($sformatf("hold_valid%0d", k), W'(out_valid), W'(1));
            check($sformatf("hold_in_ready%0d", k), W'(in_ready), W'(0));
        end
        in_valid = 1'b0;
        finish_out(32'd110, "hold");

        // Reset in the second MUL cycle discards the vector and clears weights.
        send(vecs[0].d, 1'b0, 2'd0, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_valid", W'(out_valid), W'(0));
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_mul_in", mul_in, '0);
        run_mul('0, d5, 1'b0, 2'd0, '0, "postrst");
        finish_out(32'd20, "postrst");

        // Weight write during MUL is ignored for this and the next vector.
        send(d5, 1'b0, 2'd0, '0);
        w_we   = 1'b1;
        w_addr = 2'd0;
        w_data = 32'd99;
        repeat (3) @(negedge clk);
        w_we = 1'b0;
        @(negedge clk);
        check("wmul_valid", W'(out_valid), W'(1));
        finish_out(32'd20, "wmul");
        run_mul('0, d5, 1'b0, 2'd0, '0, "wmul_next");
        finish_out(32'd20, "wmul_next");

        // The same write in IDLE applies; a write in the accept cycle applies too.
        @(negedge clk);
        w_we   = 1'b1;
        w_addr = 2'd0;
        w_data = 32'd99;
        @(negedge clk);
        w_we = 1'b0;
        run_mul(pack4(32'd99, 32'd0, 32'd0, 32'd0), d5, 1'b0, 2'd0, '0, "widle");
        finish_out(32'd119, "widle");
        run_mul(pack4(32'd99, 32'd7, 32'd0, 32'd0), d5, 1'b1, 2'd1, 32'd7, "wacc");
        finish_out(32'd126, "wacc");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
